// File: rtl/fifo_drain_scheduler.sv
// Round-robin drain of NUM_CH show-ahead FIFO read sides onto one serializer lane.
// Grants last up to BURST_MAX words; IDLE_WORD fills every ready slot with nothing to send.
module fifo_drain_scheduler #(
    parameter int                    NUM_CH     = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    BURST_MAX  = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 8'hBC,
    localparam int                   CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic                         i_enable,
    input  logic [NUM_CH-1:0]            i_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_rdata,
    input  logic                         i_ser_ready,
    output logic [NUM_CH-1:0]            o_R_en,
    output logic [DATA_WIDTH-1:0]        o_ser_data,
    output logic                         o_ser_valid,
    output logic                         o_ser_is_idle,
    output logic [CW-1:0]                o_ser_ch,
    output logic [CW-1:0]                o_grant_ch,
    output logic                         o_busy
);
    localparam int            NW      = $clog2(BURST_MAX + 1);
    localparam logic [NW-1:0] CNT_MAX = NW'(BURST_MAX);

    typedef enum logic {ARB, BURST} state_t;

    state_t          state;
    logic [NW-1:0]   cnt;
    logic [CW-1:0]   grant;

    logic            found;
    logic [CW-1:0]   sel;
    logic            cont;
    logic            take_new;
    logic            pop;
    logic [CW-1:0]   pop_ch;
    logic [DATA_WIDTH-1:0] pop_word;

    // Search starts one past the current grant, so the current holder is considered last.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = grant;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(grant) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !i_empty[idx[CW-1:0]]) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end
    end

    assign cont     = (state == BURST) && !i_empty[grant] && (cnt < CNT_MAX) && i_enable;
    assign take_new = !cont && i_enable && found;
    assign pop      = i_ser_ready && (cont || take_new);
    assign pop_ch   = cont ? grant : sel;
    assign pop_word = i_rdata[pop_ch*DATA_WIDTH +: DATA_WIDTH];

    // Pop strobe is gated by reset so a reset cycle never consumes a FIFO word.
    always_comb begin
        o_R_en = '0;
        if (pop && !i_Rst) o_R_en[pop_ch] = 1'b1;
    end

    assign o_grant_ch = grant;
    assign o_busy     = (state == BURST);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= ARB;
            cnt           <= '0;
            grant         <= CW'(NUM_CH - 1);
            o_ser_data    <= IDLE_WORD;
            o_ser_valid   <= 1'b0;
            o_ser_is_idle <= 1'b1;
            o_ser_ch      <= '0;
        end else if (i_ser_ready) begin
            o_ser_valid <= 1'b1;
            if (cont || take_new) begin
                o_ser_data    <= pop_word;
                o_ser_ch      <= pop_ch;
                o_ser_is_idle <= 1'b0;
            end else begin
                o_ser_data    <= IDLE_WORD;
                o_ser_is_idle <= 1'b1;
            end
            if (cont) begin
                cnt <= cnt + NW'(1);
                if (cnt + NW'(1) == CNT_MAX) state <= ARB;
            end else if (take_new) begin
                grant <= sel;
                cnt   <= NW'(1);
                state <= (BURST_MAX == 1) ? ARB : BURST;
            end else begin
                cnt   <= '0;
                state <= ARB;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Randomized bench for fifo_drain_scheduler: FIFO contents live in bench-side arrays and a
// grant-budget reference model predicts every pop strobe and serializer output.
module tb_fifo_drain_scheduler;
  localparam int NUM_CH = 4;
  localparam int DW = 8;
  localparam int BURST_MAX = 4;
  localparam logic [DW-1:0] IDLE_WORD = 8'hBC;
  localparam int CW = 2;
  localparam int DEPTH = 64;
  localparam int CAP = 32;

  logic                  clk = 1'b0;
  logic                  i_Rst;
  logic                  i_enable;
  logic [NUM_CH-1:0]     i_empty;
  logic [NUM_CH*DW-1:0]  i_rdata;
  logic                  i_ser_ready;
  logic [NUM_CH-1:0]     o_R_en;
  logic [DW-1:0]         o_ser_data;
  logic                  o_ser_valid;
  logic                  o_ser_is_idle;
  logic [CW-1:0]         o_ser_ch;
  logic [CW-1:0]         o_grant_ch;
  logic                  o_busy;

  fifo_drain_scheduler #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_MAX(BURST_MAX), .IDLE_WORD(IDLE_WORD)
  ) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_enable(i_enable), .i_empty(i_empty), .i_rdata(i_rdata),
    .i_ser_ready(i_ser_ready), .o_R_en(o_R_en), .o_ser_data(o_ser_data),
    .o_ser_valid(o_ser_valid), .o_ser_is_idle(o_ser_is_idle), .o_ser_ch(o_ser_ch),
    .o_grant_ch(o_grant_ch), .o_busy(o_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // bench-side FIFO contents (monotonic pointers)
  logic [DW-1:0] fifo_mem [NUM_CH][DEPTH];
  int fifo_rd [NUM_CH];
  int fifo_wr [NUM_CH];

  // scoreboard: words popped but not yet seen on the serializer
  logic [DW-1:0] exp_q[$];
  // log of source channels of fresh data words
  int obs_q[$];

  // reference model: grant pointer and remaining budget of the current grant
  int m_grant;
  int m_left;
  bit m_valid;
  bit m_idle;
  int m_ch;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int fcount(input int k);
    return fifo_wr[k] - fifo_rd[k];
  endfunction

  task automatic push(input int k, input logic [DW-1:0] w);
    if (fcount(k) < CAP) begin
      fifo_mem[k][fifo_wr[k] % DEPTH] = w;
      fifo_wr[k]++;
    end
  endtask

  task automatic fill(input int k, input int n);
    for (int i = 0; i < n; i++) push(k, 8'($urandom));
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < NUM_CH; k++) begin
      i_empty[k] = (fcount(k) == 0);
      i_rdata[k*DW +: DW] = (fcount(k) > 0) ? fifo_mem[k][fifo_rd[k] % DEPTH] : 8'($urandom);
    end
  endtask

  task automatic model_reset();
    m_grant = NUM_CH - 1;
    m_left  = 0;
    m_valid = 1'b0;
    m_idle  = 1'b1;
    m_ch    = 0;
    m_data  = IDLE_WORD;
    exp_q.delete();
  endtask

  // Keep draining the granted channel while budget remains; otherwise take the next
  // non-empty channel in rotation after the current grant.
  task automatic model_pick(input bit en, output int ch, output bit fresh);
    int c;
    ch = -1;
    fresh = 1'b0;
    if (!en) return;
    if (m_left > 0 && fcount(m_grant) > 0) begin
      ch = m_grant;
      return;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (m_grant + k) % NUM_CH;
      if (fcount(c) > 0) begin
        ch = c;
        fresh = 1'b1;
        return;
      end
    end
  endtask

  // driver: one serializer cycle
  task automatic step(input bit rdy, input bit en, input bit rst);
    int pc;
    bit fresh;
    logic [NUM_CH-1:0] exp_ren;
    logic [DW-1:0] word;
    @(negedge clk);
    i_Rst = rst;
    i_ser_ready = rdy;
    i_enable = en;
    drive_fifos();
    #1;
    pc = -1;
    fresh = 1'b0;
    if (!rst && rdy) model_pick(en, pc, fresh);
    exp_ren = '0;
    if (pc >= 0) exp_ren[pc] = 1'b1;
    check("r_en", 32'(o_R_en), 32'(exp_ren));
    check("r_en_on_empty", 32'(o_R_en & i_empty), 32'd0);
    if (rst) begin
      check("rst_valid", 32'(o_ser_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_idle", 32'(o_ser_is_idle), 32'd1);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      m_valid = 1'b1;
      if (pc >= 0) begin
        word = fifo_mem[pc][fifo_rd[pc] % DEPTH];
        fifo_rd[pc]++;
        exp_q.push_back(word);
        if (fresh) begin
          m_grant = pc;
          m_left = BURST_MAX - 1;
        end else begin
          m_left--;
        end
        m_idle = 1'b0;
        m_ch = pc;
      end else begin
        m_left = 0;
        m_idle = 1'b1;
      end
    end
    check("valid", 32'(o_ser_valid), 32'(m_valid));
    check("is_idle", 32'(o_ser_is_idle), 32'(m_idle));
    check("grant", 32'(o_grant_ch), 32'(m_grant));
    check("busy", 32'(o_busy), 32'(m_left > 0));
    if (!m_idle) check("ser_ch", 32'(o_ser_ch), 32'(m_ch));
    if (!rst && rdy) begin
      if (m_idle) begin
        m_data = IDLE_WORD;
      end else if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
        m_data = exp_q.pop_front();
        obs_q.push_back(int'(o_ser_ch));
      end
    end
    check("data", 32'(o_ser_data), 32'(m_data));
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      fifo_rd[k] = 0;
      fifo_wr[k] = 0;
    end
    model_reset();
    i_Rst = 1'b1;
    i_enable = 1'b1;
    i_ser_ready = 1'b1;
    drive_fifos();
    #3;
    check("reset_valid", 32'(o_ser_valid), 32'd0);
    check("reset_idle", 32'(o_ser_is_idle), 32'd1);
    check("reset_data", 32'(o_ser_data), 32'(IDLE_WORD));
    check("reset_ser_ch", 32'(o_ser_ch), 32'd0);
    check("reset_grant", 32'(o_grant_ch), 32'(NUM_CH - 1));
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_r_en", 32'(o_R_en), 32'd0);
    step(1, 1, 1);

    // all empty: idle stream
    for (int i = 0; i < 8; i++) step(1, 1, 0);

    // only ch2, ten words
    fill(2, 10);
    obs_q.delete();
    for (int i = 0; i < 14; i++) step(1, 1, 0);
    check("ch2_word_count", 32'(obs_q.size()), 32'd10);
    foreach (obs_q[i]) check("ch2_source", 32'(obs_q[i]), 32'd2);

    // all channels full, fresh reset: 0000 1111 2222 3333 0000
    for (int k = 0; k < NUM_CH; k++) fill(k, 8);
    step(1, 1, 1);
    obs_q.delete();
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    for (int i = 0; i < 20; i++) check("rr_order", 32'(obs_q[i]), 32'((i / 4) % NUM_CH));
    for (int i = 0; i < 14; i++) step(1, 1, 0);

    // short ch0, longer ch1: 0,0,1,1,1,1,1 with no idle gap
    step(1, 1, 1);
    fill(0, 2);
    fill(1, 5);
    obs_q.delete();
    for (int i = 0; i < 9; i++) step(1, 1, 0);
    check("short_count", 32'(obs_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) check("short_order", 32'(obs_q[i]), (i < 2) ? 32'd0 : 32'd1);

    // serializer back-pressure mid-burst
    fill(3, 6);
    for (int i = 0; i < 10; i++) step(i % 2 == 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);

    // enable drops mid-burst: idle emitted, grant kept
    fill(2, 8);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    check("enable_drop_idle", 32'(o_ser_is_idle), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 1, 0);

    // reset mid-burst, then search restarts at ch0
    fill(1, 8);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    fill(0, 3);
    obs_q.delete();
    step(1, 1, 0);
    check("post_reset_ch0", 32'(obs_q.size() > 0 ? obs_q[0] : -1), 32'd0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 99) < 20) fill(k, $urandom_range(1, 3));
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 92, $urandom_range(0, 199) == 0);
    end

    // drain
    for (int i = 0; i < 200; i++) step(1, 1, 0);
    check("drained", 32'(fcount(0) + fcount(1) + fcount(2) + fcount(3)), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
